// File: rtl/alu_reg32.sv
// alu_reg32 : MIPS-style integer ALU with registered outputs.
//
// One operation is accepted every cycle and its result and flags appear
// after the next rising clock edge (latency 1, no handshake).
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset, clears all outputs
//   a        in   WIDTH  operand A; low log2(WIDTH) bits are the shift amount
//   b        in   WIDTH  operand B; shifted value and LUI source
//   aluc     in   4      opcode
//   r        out  WIDTH  registered result
//   zero     out  1      registered (r == 0)
//   carry    out  1      registered carry / borrow / last shifted-out bit
//   negative out  1      registered sign flag (r[0] for SLT)
//   overflow out  1      registered signed overflow (ADD/SUB only)

module alu_reg32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int unsigned SW  = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADDU = 4'b0000,
        OP_SUBU = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_LUI0 = 4'b1000,
        OP_LUI1 = 4'b1001,
        OP_SLTU = 4'b1010,
        OP_SLT  = 4'b1011,
        OP_SRA  = 4'b1100,
        OP_SRL  = 4'b1101,
        OP_SLL0 = 4'b1110,
        OP_SLL1 = 4'b1111
    } op_e;

    logic [SW-1:0]    w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH:0]   w_sll_ext;
    logic [WIDTH:0]   w_srl_ext;
    logic [WIDTH:0]   w_sra_ext;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_neg;
    logic             w_ovf;

    assign w_shamt = a[SW-1:0];

    // Extra top bit of the widened sum/difference is the carry/borrow.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_slt  = $signed(a) < $signed(b);
    assign w_sltu = a < b;

    // Shifts are done one bit wider so the last bit shifted out lands in
    // the guard bit; with a zero shift amount the guard bit stays 0.
    assign w_sll_ext = {1'b0, b} << w_shamt;
    assign w_srl_ext = {b, 1'b0} >> w_shamt;
    assign w_sra_ext = $signed({b, 1'b0}) >>> w_shamt;

    assign w_add_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB]  != a[MSB]);
    assign w_sub_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (op_e'(aluc))
            OP_ADDU: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUBU: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = w_add_ovf;
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_ovf = w_sub_ovf;
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_LUI0,
            OP_LUI1: w_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLTU: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_sltu};
                w_carry = w_sltu;
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SRA: begin
                w_res   = w_sra_ext[WIDTH:1];
                w_carry = w_sra_ext[0];
            end
            OP_SRL: begin
                w_res   = w_srl_ext[WIDTH:1];
                w_carry = w_srl_ext[0];
            end
            OP_SLL0,
            OP_SLL1: begin
                w_res   = w_sll_ext[WIDTH-1:0];
                w_carry = w_sll_ext[WIDTH];
            end
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end

    // SLT reports its comparison outcome on the sign flag.
    assign w_neg = (op_e'(aluc) == OP_SLT) ? w_res[0] : w_res[MSB];

    always_ff @(posedge clk) begin
        if (rst) begin
            r        <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            r        <= w_res;
            zero     <= (w_res == '0);
            carry    <= w_carry;
            negative <= w_neg;
            overflow <= w_ovf;
        end
    end

endmodule

// File: tb/tb_alu_reg32.sv
// tb_alu_reg32 : directed-vector bench for alu_reg32.
// Each vector packs the expected outputs as {r, zero, carry, negative, overflow}.

module tb_alu_reg32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [31:0] r;
    logic        zero;
    logic        carry;
    logic        negative;
    logic        overflow;

    int unsigned n_vec;
    int unsigned n_err;

    alu_reg32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .aluc     (aluc),
        .r        (r),
        .zero     (zero),
        .carry    (carry),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic alu_check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got r=%h z=%b c=%b n=%b v=%b, expected r=%h z=%b c=%b n=%b v=%b",
                     tag, got[35:4], got[3], got[2], got[1], got[0],
                     exp[35:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Present one op, clock it in, sample just after the edge.
    task automatic step(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [3:0] op, input logic [31:0] er,
                        input logic ez, input logic ec, input logic en, input logic eo);
        a    = ia;
        b    = ib;
        aluc = op;
        @(posedge clk);
        #1;
        alu_check(tag, {r, zero, carry, negative, overflow}, {er, ez, ec, en, eo});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        a     = 32'd5;
        b     = 32'd3;
        aluc  = 4'b0000;

        // Reset held two cycles with a live op on the inputs.
        @(posedge clk); #1;
        alu_check("rst_c1", {r, zero, carry, negative, overflow}, 36'h0);
        @(posedge clk); #1;
        alu_check("rst_c2", {r, zero, carry, negative, overflow}, 36'h0);
        rst = 1'b0;
        step("post_rst", 32'd5, 32'd3, 4'b0000, 32'd8, 0, 0, 0, 0);

        // Reference vector a=0x1F, b=0xFFFF.
        step("addu",  32'h1F, 32'hFFFF, 4'b0000, 32'h0001001E, 0, 0, 0, 0);
        step("subu",  32'h1F, 32'hFFFF, 4'b0001, 32'hFFFF0020, 0, 1, 1, 0);
        step("and",   32'h1F, 32'hFFFF, 4'b0100, 32'h0000001F, 0, 0, 0, 0);
        step("or",    32'h1F, 32'hFFFF, 4'b0101, 32'h0000FFFF, 0, 0, 0, 0);
        step("xor",   32'h1F, 32'hFFFF, 4'b0110, 32'h0000FFE0, 0, 0, 0, 0);
        step("nor",   32'h1F, 32'hFFFF, 4'b0111, 32'hFFFF0000, 0, 0, 1, 0);
        step("lui0",  32'h1F, 32'hFFFF, 4'b1000, 32'hFFFF0000, 0, 0, 1, 0);
        step("lui1",  32'h1F, 32'hFFFF, 4'b1001, 32'hFFFF0000, 0, 0, 1, 0);
        step("slt",   32'h1F, 32'hFFFF, 4'b1011, 32'h00000001, 0, 0, 1, 0);
        step("sltu",  32'h1F, 32'hFFFF, 4'b1010, 32'h00000001, 0, 1, 0, 0);
        step("sll0",  32'h1F, 32'hFFFF, 4'b1110, 32'h80000000, 0, 1, 1, 0);
        step("sll1",  32'h1F, 32'hFFFF, 4'b1111, 32'h80000000, 0, 1, 1, 0);
        step("srl",   32'h1F, 32'hFFFF, 4'b1101, 32'h00000000, 1, 0, 0, 0);
        step("sra",   32'h1F, 32'hFFFF, 4'b1100, 32'h00000000, 1, 0, 0, 0);

        // Signed overflow and its absence on the unsigned forms.
        step("add_ovf",    32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 0, 0, 1, 1);
        step("sub_ovf",    32'h80000000, 32'h1, 4'b0011, 32'h7FFFFFFF, 0, 0, 0, 1);
        step("addu_noovf", 32'h7FFFFFFF, 32'h1, 4'b0000, 32'h80000000, 0, 0, 1, 0);
        step("subu_noovf", 32'h80000000, 32'h1, 4'b0001, 32'h7FFFFFFF, 0, 0, 0, 0);
        step("add_negovf", 32'h80000000, 32'h80000000, 4'b0010, 32'h0, 1, 0, 0, 1);
        step("sub_plain",  32'd5, 32'd7, 4'b0011, 32'hFFFFFFFE, 0, 0, 1, 0);
        step("subu_borrow",32'd5, 32'd7, 4'b0001, 32'hFFFFFFFE, 0, 1, 1, 0);

        // Signed vs unsigned compare: -1 vs 1 and swapped.
        step("slt_m1_1",   32'hFFFFFFFF, 32'h1, 4'b1011, 32'h1, 0, 0, 1, 0);
        step("sltu_m1_1",  32'hFFFFFFFF, 32'h1, 4'b1010, 32'h0, 1, 0, 0, 0);
        step("slt_1_m1",   32'h1, 32'hFFFFFFFF, 4'b1011, 32'h0, 1, 0, 0, 0);
        step("sltu_1_m1",  32'h1, 32'hFFFFFFFF, 4'b1010, 32'h1, 0, 1, 0, 0);

        // Edge cases.
        step("addu_wrap",  32'hFFFFFFFF, 32'h1, 4'b0000, 32'h0, 1, 1, 0, 0);
        step("subu_eq",    32'h12345678, 32'h12345678, 4'b0001, 32'h0, 1, 0, 0, 0);
        step("sra_neg31",  32'd31, 32'h80000000, 4'b1100, 32'hFFFFFFFF, 0, 0, 1, 0);
        step("sll_shamt0", 32'h20, 32'hDEADBEEF, 4'b1110, 32'hDEADBEEF, 0, 0, 1, 0);
        step("srl_s4",     32'h24, 32'h80000008, 4'b1101, 32'h08000000, 0, 1, 0, 0);
        step("sra_s5",     32'h25, 32'h80000010, 4'b1100, 32'hFC000000, 0, 1, 1, 0);
        step("sll_s2",     32'h2,  32'h40000001, 4'b1111, 32'h00000004, 0, 1, 0, 0);

        // Reset mid-stream discards the op presented with it.
        rst = 1'b1;
        step("rst_mid", 32'hFFFFFFFF, 32'h1, 4'b0000, 32'h0, 0, 0, 0, 0);
        rst = 1'b0;
        step("after_rst_mid", 32'hFFFFFFFF, 32'h1, 4'b0000, 32'h0, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
